rx_header_dec: RTL and testbench

Receive-side packet-header stage directly downstream of the sync-word correlator. It starts on the correlator's trigger pulse, skips the 4 trailer bits, then collects the 54-bit FEC-1/3 header. Each header triplet is majority-voted and de-whitened, and the HEC is recomputed against the UAP. The block publishes the decoded header fields, the HEC result and a payload-start strobe to the baseband RX controller.

---
 rtl/rx_header_dec.sv | 237 +++++++++++++++++++++++
 tb/tb_rx_header_dec.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_header_dec.sv
// rx_header_dec: packet-header decoder behind the sync-word correlator.
// It skips the trailer bits after the trigger, majority-votes the FEC-1/3
// header triplets, de-whitens them, checks the HEC against the UAP, and
// publishes the decoded fields together with completion strobes.
`timescale 1ns/1ps
module rx_header_dec #(
    parameter int TRAILER_BITS   = 4,
    parameter int HDR_CODED_BITS = 54
) (
    input  logic       clk_6M,
    input  logic       rstz,
    input  logic       p_1us,
    input  logic       corre_trgp,
    input  logic       rxbit,
    input  logic       rx_abort,
    input  logic       whiten_en,
    input  logic [5:0] whiten_init,
    input  logic [7:0] uap,
    output logic [2:0] hdr_lt_addr,
    output logic [3:0] hdr_type,
    output logic       hdr_flow,
    output logic       hdr_arqn,
    output logic       hdr_seqn,
    output logic       hdr_hec_ok,
    output logic [4:0] fec_corr_cnt,
    output logic       hdr_busy,
    output logic       hdr_valid_p,
    output logic       payload_st_p,
    output logic       hdr_err_p
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRAILER = 2'd1,
        ST_HDR     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [5:0] TRAIL_LAST_C = 6'(TRAILER_BITS - 1);
    localparam logic [5:0] HDR_LAST_C   = 6'(HDR_CODED_BITS - 1);
    localparam logic [4:0] HEC_FIRST_C  = 5'd10;
    localparam logic [7:0] HEC_POLY_C   = 8'hA7;

    // Two-of-three majority vote of one coded triplet.
    function automatic logic maj3(input logic [2:0] b);
        return (b[0] & b[1]) | (b[0] & b[2]) | (b[1] & b[2]);
    endfunction

    // One step of the x^7+x^4+1 whitening LFSR.
    function automatic logic [6:0] whiten_step(input logic [6:0] w);
        return {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
    endfunction

    // One step of the HEC generator LFSR for info bit d.
    function automatic logic [7:0] hec_step(input logic [7:0] h, input logic d);
        logic fb;
        fb = d ^ h[7];
        return {h[6:0], 1'b0} ^ (fb ? HEC_POLY_C : 8'h00);
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    state_t      fsm_nxt_s;
    logic [5:0]  bit_cnt_r;
    logic [1:0]  ph_r;
    logic [1:0]  trip_r;
    logic [4:0]  idx_r;
    logic [6:0]  w_r;
    logic [7:0]  hec_r;
    logic        hec_ok_r;
    logic [9:0]  info_r;
    logic        hdr_hec_ok_r;
    logic [4:0]  fec_corr_cnt_r;
    logic        busy_r;
    logic        valid_r;
    logic        payload_r;
    logic        err_r;

    logic        start_s;
    logic [2:0]  trip_s;
    logic        trip_end_s;
    logic        maj_s;
    logic        disagree_s;
    logic        dec_s;
    logic        is_hec_bit_s;
    logic        hec_ok_nxt_s;
    logic        load_pre_s;
    logic        last_pre_s;
    logic        load_s;
    logic        last_s;

    // Next-state logic plus the triplet vote / de-whiten / HEC-compare datapath.
    always_comb begin
        start_s      = corre_trgp & p_1us;
        trip_s       = {trip_r, rxbit};
        trip_end_s   = (state_r == ST_HDR) & p_1us & (ph_r == 2'd2);
        maj_s        = maj3(trip_s);
        disagree_s   = ~((trip_s == 3'b000) | (trip_s == 3'b111));
        dec_s        = maj_s ^ (whiten_en & w_r[6]);
        is_hec_bit_s = (idx_r >= HEC_FIRST_C);
        hec_ok_nxt_s = hec_ok_r;
        load_pre_s   = 1'b0;
        last_pre_s   = 1'b0;
        fsm_nxt_s    = state_r;
        if (trip_end_s && is_hec_bit_s) begin
            hec_ok_nxt_s = hec_ok_r & (dec_s == hec_r[7]);
        end else begin
            hec_ok_nxt_s = hec_ok_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    fsm_nxt_s  = ST_TRAILER;
                    load_pre_s = 1'b1;
                end else begin
                    fsm_nxt_s = ST_IDLE;
                end
            end
            ST_TRAILER: begin
                if (start_s) begin
                    fsm_nxt_s  = ST_TRAILER;
                    load_pre_s = 1'b1;
                end else if (p_1us && (bit_cnt_r == TRAIL_LAST_C)) begin
                    fsm_nxt_s = ST_HDR;
                end else begin
                    fsm_nxt_s = ST_TRAILER;
                end
            end
            ST_HDR: begin
                if (start_s) begin
                    fsm_nxt_s  = ST_TRAILER;
                    load_pre_s = 1'b1;
                end else if (p_1us && (bit_cnt_r == HDR_LAST_C)) begin
                    fsm_nxt_s  = ST_DONE;
                    last_pre_s = 1'b1;
                end else begin
                    fsm_nxt_s = ST_HDR;
                end
            end
            ST_DONE: begin
                fsm_nxt_s = ST_IDLE;
            end
            default: begin
                fsm_nxt_s = ST_IDLE;
            end
        endcase
        state_nxt_s = rx_abort ? ST_IDLE : fsm_nxt_s;
        load_s      = load_pre_s & ~rx_abort;
        last_s      = last_pre_s & ~rx_abort;
    end

    // State register.
    always_ff @(posedge clk_6M) begin
        if (!rstz) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counters, seeds, decoded fields and registered completion strobes.
    always_ff @(posedge clk_6M) begin
        if (!rstz) begin
            bit_cnt_r      <= 6'd0;
            ph_r           <= 2'd0;
            trip_r         <= 2'd0;
            idx_r          <= 5'd0;
            w_r            <= 7'd0;
            hec_r          <= 8'd0;
            hec_ok_r       <= 1'b0;
            info_r         <= 10'd0;
            hdr_hec_ok_r   <= 1'b0;
            fec_corr_cnt_r <= 5'd0;
            busy_r         <= 1'b0;
            valid_r        <= 1'b0;
            payload_r      <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            valid_r   <= 1'b0;
            payload_r <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= (state_nxt_s != ST_IDLE);
            if (load_s) begin
                bit_cnt_r      <= 6'd0;
                ph_r           <= 2'd0;
                trip_r         <= 2'd0;
                idx_r          <= 5'd0;
                w_r            <= {1'b1, whiten_init};
                hec_r          <= uap;
                hec_ok_r       <= 1'b1;
                info_r         <= 10'd0;
                fec_corr_cnt_r <= 5'd0;
            end else if (!rx_abort && (state_r == ST_TRAILER) && p_1us) begin
                bit_cnt_r <= (bit_cnt_r == TRAIL_LAST_C) ? 6'd0 : bit_cnt_r + 6'd1;
            end else if (!rx_abort && (state_r == ST_HDR) && p_1us) begin
                bit_cnt_r <= bit_cnt_r + 6'd1;
                trip_r    <= trip_s[1:0];
                if (ph_r == 2'd2) begin
                    ph_r     <= 2'd0;
                    idx_r    <= idx_r + 5'd1;
                    w_r      <= whiten_step(w_r);
                    hec_ok_r <= hec_ok_nxt_s;
                    if (disagree_s) begin
                        fec_corr_cnt_r <= fec_corr_cnt_r + 5'd1;
                    end
                    if (!is_hec_bit_s) begin
                        info_r[idx_r[3:0]] <= dec_s;
                        hec_r              <= hec_step(hec_r, dec_s);
                    end else begin
                        hec_r <= {hec_r[6:0], 1'b0};
                    end
                end else begin
                    ph_r <= ph_r + 2'd1;
                end
                if (last_s) begin
                    valid_r      <= 1'b1;
                    payload_r    <= hec_ok_nxt_s;
                    err_r        <= ~hec_ok_nxt_s;
                    hdr_hec_ok_r <= hec_ok_nxt_s;
                end
            end
        end
    end

    assign hdr_lt_addr  = info_r[2:0];
    assign hdr_type     = info_r[6:3];
    assign hdr_flow     = info_r[7];
    assign hdr_arqn     = info_r[8];
    assign hdr_seqn     = info_r[9];
    assign hdr_hec_ok   = hdr_hec_ok_r;
    assign fec_corr_cnt = fec_corr_cnt_r;
    assign hdr_busy     = busy_r;
    assign hdr_valid_p  = valid_r;
    assign payload_st_p = payload_r;
    assign hdr_err_p    = err_r;

endmodule

// File: tb/tb_rx_header_dec.sv
// Self-checking bench for rx_header_dec: directed and randomized headers
// against a reference model built from the header coding rules.
`timescale 1ns/1ps
module tb_rx_header_dec;

    logic       clk_6M = 1'b0;
    logic       rstz = 1'b0;
    logic       p_1us = 1'b0;
    logic       corre_trgp = 1'b0;
    logic       rxbit = 1'b0;
    logic       rx_abort = 1'b0;
    logic       whiten_en = 1'b0;
    logic [5:0] whiten_init = 6'd0;
    logic [7:0] uap = 8'd0;
    logic [2:0] hdr_lt_addr;
    logic [3:0] hdr_type;
    logic       hdr_flow, hdr_arqn, hdr_seqn, hdr_hec_ok;
    logic [4:0] fec_corr_cnt;
    logic       hdr_busy, hdr_valid_p, payload_st_p, hdr_err_p;

    int   vectors = 0;
    int   miscompares = 0;
    logic stray = 1'b0;
    logic m_ok = 1'b0;

    rx_header_dec dut (
        .clk_6M(clk_6M), .rstz(rstz), .p_1us(p_1us), .corre_trgp(corre_trgp),
        .rxbit(rxbit), .rx_abort(rx_abort), .whiten_en(whiten_en),
        .whiten_init(whiten_init), .uap(uap), .hdr_lt_addr(hdr_lt_addr),
        .hdr_type(hdr_type), .hdr_flow(hdr_flow), .hdr_arqn(hdr_arqn),
        .hdr_seqn(hdr_seqn), .hdr_hec_ok(hdr_hec_ok), .fec_corr_cnt(fec_corr_cnt),
        .hdr_busy(hdr_busy), .hdr_valid_p(hdr_valid_p), .payload_st_p(payload_st_p),
        .hdr_err_p(hdr_err_p)
    );

    always #83 clk_6M = ~clk_6M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic strobe(input logic trg, input logic b, input logic abt);
        p_1us = 1'b1; corre_trgp = trg; rxbit = b; rx_abort = abt;
        tick();
        p_1us = 1'b0; corre_trgp = 1'b0; rx_abort = 1'b0;
        rxbit = 1'($urandom_range(0, 1));
    endtask

    task automatic note_pulses();
        if (hdr_valid_p | payload_st_p | hdr_err_p) stray = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            note_pulses();
        end
    endtask

    // HEC as the remainder of the 10 info bits under generator 0xA7, seeded with the UAP.
    function automatic logic [7:0] hec_of(input logic [7:0] seed, input logic [9:0] f);
        logic [7:0] h;
        logic       top;
        h = seed;
        for (int i = 0; i < 10; i++) begin
            top = h[7];
            h   = h << 1;
            if (top != f[i]) h = h ^ 8'hA7;
        end
        return h;
    endfunction

    // Whitening bit applied to each of the 18 info bits.
    function automatic logic [17:0] wseq(input logic [5:0] wi);
        logic [6:0]  w;
        logic [17:0] s;
        logic        o;
        w = {1'b1, wi};
        for (int i = 0; i < 18; i++) begin
            s[i] = w[6];
            o    = w[6];
            w    = {w[5:0], o};
            w[4] = w[4] ^ o;
        end
        return s;
    endfunction

    // stop_at = n > 0: abort (or reset) on the strobe carrying header bit n.
    task automatic send_packet(input string name, input logic [9:0] f, input logic we,
                               input logic [5:0] wi, input logic [7:0] u,
                               input logic [53:0] flips, input int stop_at,
                               input logic stop_is_reset);
        logic [17:0] info, ws, rx;
        logic [53:0] coded;
        logic [7:0]  h, rxh;
        logic        exp_ok;
        int          nflip, corr;
        h = hec_of(u, f);
        info[9:0] = f;
        for (int j = 0; j < 8; j++) info[10 + j] = h[7 - j];
        ws   = wseq(wi);
        corr = 0;
        for (int i = 0; i < 18; i++) begin
            nflip = int'(flips[3*i]) + int'(flips[3*i+1]) + int'(flips[3*i+2]);
            for (int k = 0; k < 3; k++) coded[3*i+k] = info[i] ^ (we & ws[i]) ^ flips[3*i+k];
            rx[i] = info[i] ^ (nflip >= 2);
            if (nflip == 1 || nflip == 2) corr++;
        end
        for (int j = 0; j < 8; j++) rxh[7 - j] = rx[10 + j];
        exp_ok = (hec_of(u, rx[9:0]) == rxh);

        whiten_en = we; whiten_init = wi; uap = u;
        stray = 1'b0;
        strobe(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        note_pulses();
        chk({name, ".busy_start"}, 32'(hdr_busy), 32'd1);
        idle(5);
        for (int t = 0; t < 4; t++) begin
            strobe(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            note_pulses();
            idle(5);
        end
        for (int i = 0; i < 54; i++) begin
            if (stop_at == i + 1) begin
                if (stop_is_reset) begin
                    rstz = 1'b0;
                    strobe(1'b0, coded[i], 1'b0);
                    rstz = 1'b1;
                    chk({name, ".reset_outs"}, 32'({hdr_lt_addr, hdr_type, hdr_flow, hdr_arqn,
                        hdr_seqn, hdr_hec_ok, fec_corr_cnt, hdr_busy, hdr_valid_p,
                        payload_st_p, hdr_err_p}), 32'd0);
                    chk({name, ".no_stray"}, 32'(stray), 32'd0);
                    m_ok = 1'b0;
                    idle(10);
                end else begin
                    strobe(1'b0, coded[i], 1'b1);
                    note_pulses();
                    chk({name, ".abort_busy"}, 32'(hdr_busy), 32'd0);
                    chk({name, ".abort_hec_ok"}, 32'(hdr_hec_ok), 32'(m_ok));
                    idle(60);
                    chk({name, ".abort_no_pulse"}, 32'(stray), 32'd0);
                end
                return;
            end
            strobe(1'b0, coded[i], 1'b0);
            if (i < 53) begin
                note_pulses();
                idle(5);
            end
        end
        chk({name, ".no_early_pulse"}, 32'(stray), 32'd0);
        chk({name, ".valid"}, 32'(hdr_valid_p), 32'd1);
        chk({name, ".payload_st"}, 32'(payload_st_p), 32'(exp_ok));
        chk({name, ".err"}, 32'(hdr_err_p), 32'(!exp_ok));
        chk({name, ".hec_ok"}, 32'(hdr_hec_ok), 32'(exp_ok));
        chk({name, ".fields"}, 32'({hdr_seqn, hdr_arqn, hdr_flow, hdr_type, hdr_lt_addr}),
            32'(rx[9:0]));
        chk({name, ".fec_cnt"}, 32'(fec_corr_cnt), 32'(corr));
        chk({name, ".busy_done"}, 32'(hdr_busy), 32'd1);
        m_ok = exp_ok;
        tick();
        chk({name, ".pulse_end"}, 32'({hdr_valid_p, payload_st_p, hdr_err_p}), 32'd0);
        chk({name, ".busy_end"}, 32'(hdr_busy), 32'd0);
        idle(4);
    endtask

    initial begin
        logic [9:0]  tp;
        logic [53:0] fl;
        int          r;
        tp = {1'b1, 1'b0, 1'b1, 4'h4, 3'd5};

        rstz = 1'b0;
        tick(); tick(); tick();
        chk("reset_outs", 32'({hdr_lt_addr, hdr_type, hdr_flow, hdr_arqn, hdr_seqn,
            hdr_hec_ok, fec_corr_cnt, hdr_busy, hdr_valid_p, payload_st_p, hdr_err_p}), 32'd0);
        rstz = 1'b1;
        idle(3);

        send_packet("clean", tp, 1'b0, 6'h00, 8'h00, 54'd0, 0, 1'b0);
        send_packet("whiten", tp, 1'b1, 6'h2A, 8'h00, 54'd0, 0, 1'b0);

        fl = 54'd0;
        fl[1] = 1'b1; fl[9] = 1'b1; fl[23] = 1'b1; fl[37] = 1'b1; fl[51] = 1'b1;
        send_packet("five_single", tp, 1'b1, 6'h2A, 8'h47, fl, 0, 1'b0);

        fl = 54'd0;
        fl[9] = 1'b1; fl[10] = 1'b1;
        send_packet("double_flip", tp, 1'b0, 6'h00, 8'h00, fl, 0, 1'b0);

        send_packet("abort", tp, 1'b1, 6'h15, 8'h9C, 54'd0, 20, 1'b0);
        send_packet("after_abort", tp, 1'b1, 6'h15, 8'h9C, 54'd0, 0, 1'b0);

        // Trigger, two trailer strobes, then a second trigger that must restart timing.
        whiten_en = 1'b0; uap = 8'h3C;
        strobe(1'b1, 1'b0, 1'b0); idle(5);
        strobe(1'b0, 1'b1, 1'b0); idle(5);
        strobe(1'b0, 1'b0, 1'b0); idle(5);
        send_packet("retrigger", 10'h2B7, 1'b0, 6'h00, 8'h3C, 54'd0, 0, 1'b0);

        fl = 54'd0;
        fl[4] = 1'b1; fl[12] = 1'b1;
        send_packet("reset_mid", 10'h3FF, 1'b0, 6'h00, 8'h11, fl, 33, 1'b1);
        send_packet("after_reset", 10'h1A5, 1'b1, 6'h07, 8'h11, 54'd0, 0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            fl = 54'd0;
            for (int i = 0; i < 18; i++) begin
                r = int'($urandom_range(0, 9));
                if (r >= 6) fl[3*i + int'($urandom_range(0, 2))] = 1'b1;
                if (r == 9) begin
                    fl[3*i]   = 1'b1;
                    fl[3*i+2] = 1'b1;
                    fl[3*i+1] = 1'b0;
                end
            end
            send_packet("random", 10'($urandom), 1'($urandom), 6'($urandom), 8'($urandom),
                        fl, 0, 1'b0);
            idle(int'($urandom_range(1, 20)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
